// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: bit order, hex glyph patterns and the blank pattern.
package seven_seg_pkg;

    localparam int unsigned SEG_W = 7;

    // Segment bit positions within a 7-bit pattern
    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F = 1;
    localparam int unsigned SEG_G = 0;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b1000111;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seven_segment_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (nibble)
            4'h0: seg_c = SEG_HEX_0;
            4'h1: seg_c = SEG_HEX_1;
            4'h2: seg_c = SEG_HEX_2;
            4'h3: seg_c = SEG_HEX_3;
            4'h4: seg_c = SEG_HEX_4;
            4'h5: seg_c = SEG_HEX_5;
            4'h6: seg_c = SEG_HEX_6;
            4'h7: seg_c = SEG_HEX_7;
            4'h8: seg_c = SEG_HEX_8;
            4'h9: seg_c = SEG_HEX_9;
            4'hA: seg_c = SEG_HEX_A;
            4'hB: seg_c = SEG_HEX_B;
            4'hC: seg_c = SEG_HEX_C;
            4'hD: seg_c = SEG_HEX_D;
            4'hE: seg_c = SEG_HEX_E;
            4'hF: seg_c = SEG_HEX_F;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_mux.sv
// N-digit time-multiplexed seven-segment driver with blink, decimal point,
// leading-zero blanking and configurable pin polarity.
module seven_segment_mux
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLINK_W        = 24,
    parameter int unsigned SEG_ACTIVE_LOW = 0,
    parameter int unsigned AN_ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bin_in,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [BLINK_W-1:0]      blink_rate,
    input  logic                    blank_lz,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [SEG_W-1:0]      SEG_INV = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [NUM_DIGITS-1:0][3:0] sh_bin;
    logic [NUM_DIGITS-1:0]      sh_dp;
    logic [NUM_DIGITS-1:0]      sh_blink;

    logic [REF_W-1:0]   ref_cnt;
    logic [IDX_W-1:0]   idx;
    logic [BLINK_W-1:0] blk_cnt;
    logic               phase;

    logic [3:0]            nib_c;
    logic [SEG_W-1:0]      dec_seg_c;
    logic [NUM_DIGITS-1:0] lz_c;
    logic                  lz_run_c;
    logic                  blink_off_c;
    logic                  lz_off_c;
    logic [SEG_W-1:0]      seg_nxt_c;
    logic                  dp_nxt_c;
    logic [NUM_DIGITS-1:0] an_nxt_c;

    // Shadow registers: the display only ever reads these
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_bin   <= '0;
            sh_dp    <= '0;
            sh_blink <= '0;
        end else if (load) begin
            sh_bin   <= bin_in;
            sh_dp    <= dp_en;
            sh_blink <= blink_mask;
        end
    end

    // Dwell counter and digit index; idx never leaves 0..NUM_DIGITS-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    // Blink half-period counter; >= compare handles blink_rate shrinking mid-count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt <= '0;
            phase   <= 1'b1;
        end else if (blink_rate == '0) begin
            blk_cnt <= '0;
            phase   <= 1'b1;
        end else if (blk_cnt >= blink_rate - BLINK_W'(1)) begin
            blk_cnt <= '0;
            phase   <= ~phase;
        end else begin
            blk_cnt <= blk_cnt + BLINK_W'(1);
        end
    end

    // lz_c[i]: digit i and every higher digit hold zero
    always_comb begin
        lz_run_c = 1'b1;
        lz_c     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run_c = lz_run_c & (sh_bin[i] == 4'h0);
            lz_c[i]  = lz_run_c;
        end
    end

    assign nib_c = sh_bin[idx];

    seven_segment_decoder u_decoder (
        .nibble (nib_c),
        .seg_c  (dec_seg_c)
    );

    always_comb begin
        blink_off_c = sh_blink[idx] & ~phase;
        lz_off_c    = blank_lz & (idx != '0) & lz_c[idx];
        seg_nxt_c   = dec_seg_c;
        dp_nxt_c    = sh_dp[idx];
        an_nxt_c    = NUM_DIGITS'(1) << idx;
        if (blink_off_c) begin
            seg_nxt_c = SEG_BLANK;
            dp_nxt_c  = 1'b0;
        end else if (lz_off_c) begin
            seg_nxt_c = SEG_BLANK;
        end
    end

    // Output register; polarity applied after blanking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_INV;
            dp  <= DP_INV;
            an  <= AN_INV;
        end else begin
            seg <= seg_nxt_c ^ SEG_INV;
            dp  <= dp_nxt_c ^ DP_INV;
            an  <= an_nxt_c ^ AN_INV;
        end
    end

endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Time-multiplexed driver for an N-digit seven-segment display. It replaces the single-digit decoder with a parametrised scanner that cycles a one-hot digit enable at a programmable refresh rate. It also adds per-digit blink, per-digit decimal point, optional leading-zero blanking and selectable output polarity. It sits between the display-value registers and the board-level segment and anode pins.

## Interface
- `NUM_DIGITS`, 4, number of digits scanned (≥1)
- `REFRESH_DIV`, 50000, clock cycles each digit stays enabled (≥1)
- `BLINK_W`, 24, width of `blink_rate`
- `SEG_ACTIVE_LOW`, 0, 1 inverts `seg` and `dp` at the pins
- `AN_ACTIVE_LOW`, 0, 1 inverts `an` at the pins

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `load`  in  1  capture `bin_in`, `dp_en` and `blink_mask` into shadow registers
- `bin_in`  in  4*NUM_DIGITS  hex nibble per digit; digit 0 is in bits [3:0]
- `dp_en`  in  NUM_DIGITS  per-digit decimal point
- `blink_mask`  in  NUM_DIGITS  per-digit blink enable
- `blink_rate`  in  BLINK_W  cycles per blink half-period; 0 disables blinking
- `blank_lz`  in  1  enables leading-zero blanking (live, not shadowed)
- `seg`  out  7  segments; bit 6 = A, bit 0 = G
- `dp`  out  1  decimal point of the active digit
- `an`  out  NUM_DIGITS  one-hot digit enable

## Operation
- **Shadow registers.** When `load`=1 at a clock edge, the shadow registers take `bin_in`, `dp_en` and `blink_mask`. The display uses only shadow values.
- **Refresh counter.**
  - `ref_cnt` counts 0..REFRESH_DIV-1.
  - At terminal count, `ref_cnt` returns to 0 and `idx` advances.
  - `idx` wraps from NUM_DIGITS-1 to 0.
  - If REFRESH_DIV=1, `idx` advances every cycle.
- **Blink.**
  - `blk_cnt` counts 0..`blink_rate`-1. When `blk_cnt` ≥ `blink_rate`-1, `blk_cnt` goes to 0 and `phase` toggles.
  - If `blink_rate` is lowered below the current count, the next cycle hits terminal count.
  - If `blink_rate`=0, `blk_cnt` is held at 0 and `phase` is held at 1 (visible).
- **Output register.** Updated every cycle from the current `idx` and shadow values:
  - `an` = onehot(`idx`).
  - `seg` = hex decode of nibble[`idx`].
  - `dp` = `dp_en`[`idx`].
- **Blanking.** `seg` is forced to 0 and `dp` to 0, with `an` still asserted, when either condition holds:
  - `blink_mask`[`idx`]=1 and `phase`=0; or
  - `blank_lz`=1, `idx`≠0, and nibble[`idx`] and every higher nibble are 0. Leading-zero blanking leaves `dp` intact.
- **Hex decode (active-high).**
  - 0 → 1111110, 1 → 0110000, 2 → 1101101, 3 → 1111001
  - 4 → 0110011, 5 → 1011011, 6 → 1011111, 7 → 1110000
  - 8 → 1111111, 9 → 1111011, A → 1110111, b → 0011111
  - C → 1001110, d → 0111101, E → 1001111, F → 1000111
- **Polarity.** Inversion is applied after blanking, so an "off" pin always reads inactive in the configured polarity.

## Timing
- **Reset (async assert).** Takes effect immediately, without waiting for a clock edge:
  - `seg`, `dp` and `an` go to the inactive level: all 0 when the polarity parameters are 0.
  - `ref_cnt`, `blk_cnt`, `idx` and the shadow registers go to 0; `phase` goes to 1.
  - Release takes effect at the next rising edge.
- **First cycle after release.** `an` = onehot(0).
- **Output latency.**
  - 1 cycle from any change of `idx`, `phase` or the shadow registers to the pins.
  - 2 cycles from `load` being sampled to the new value appearing on the pins.
  - `blank_lz` reaches the pins 1 cycle after it changes.
- **Dwell and frame.** Each `an` pattern is held for exactly REFRESH_DIV cycles. A full frame is NUM_DIGITS×REFRESH_DIV cycles.
- **Simultaneous events.**
  - `load` coinciding with the refresh terminal count: the new digit shows the newly loaded value one cycle later. No glitch cycle with an out-of-range `idx` is allowed.
  - A blink toggle and a digit advance in the same cycle are independent of each other.
- **Reset mid-scan.** Scanning restarts at digit 0 with the full REFRESH_DIV dwell.

## Structure
- Shared package/header `seven_seg_pkg`:
  - the 16 hex segment constants;
  - the segment bit-order definitions (A = bit 6 .. G = bit 0);
  - the blank constant 7'b0000000.
- Sub-module `seven_segment_decoder`: combinational nibble → 7-bit active-high pattern. It is instantiated once, on the muxed nibble.
- The top level holds the shadow registers, refresh counter, blink counter, leading-zero detect, output register and polarity stage.

## Test plan
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4.
- **Reset:** hold `rst`=0 → `seg`=0000000, `dp`=0, `an`=0000. Release → `an`=0001 on the first edge.
- **Scan:** `load` with `bin_in`=16'h1234 → digit 0 shows 0110011 with `an`=0001 for 4 cycles, then digit 1 shows 1111001 with `an`=0010. `an` returns to 0001 after 16 cycles.
- **Blink:** `blink_rate`=8, `blink_mask`=0001 → digit 0 `seg`/`dp` alternate between visible and 0 every 8 cycles; digits 1–3 are unaffected. Setting `blink_rate`=0 → digit 0 stays visible.
- **Leading-zero blanking:** `bin_in`=16'h0050, `blank_lz`=1 → digits 3 and 2 show 0000000, digit 1 shows 1011011, digit 0 shows 1111110. With `bin_in`=16'h0000, only digit 0 shows 1111110.
- **Reset mid-scan:** assert `rst` during digit 2 → pins go inactive immediately. After release, the scan resumes at `an`=0001 for a full 4 cycles.
- **Polarity:** SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, digit 0 = 8 → `seg`=0000000 and `an`=1110. During reset, `seg`=1111111, `dp`=1 and `an`=1111.
